// File: rtl/alu_issue_if.sv
// alu_issue_if
// Command channel into the ALU issue block.
//
// Signals:
//   cmd_valid  upstream has a command this cycle
//   cmd_ready  issue block can take a command this cycle
//   cmd_a      operand A (4 bits)
//   cmd_b      operand B (4 bits)
//   cmd_ctl    opcode (4 bits, same encoding as the ALU)
//
// Modports:
//   master  the command producer
//   slave   the issue block
interface alu_issue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_ctl;

    modport master (
        output cmd_valid,
        output cmd_a,
        output cmd_b,
        output cmd_ctl,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_a,
        input  cmd_b,
        input  cmd_ctl,
        output cmd_ready
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue
// Queues ALU commands in a small FIFO and issues them to a single-cycle
// ALU, one per cycle.  Carry-consuming ops (ADD_c, SUB_b) are held back
// until the carry produced by the previous op is available.
//
// Parameters:
//   DEPTH       command FIFO depth, power of two, 2..16
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   cmd         command channel (alu_issue_if.slave)
//   flag_clr    synchronous clear of the carry flag
//   valid_in    issued op valid (registered)
//   a, b, ctl   issued operands and opcode (registered)
//   cin         issued carry-in (registered)
//   valid_out   ALU result valid
//   carry       ALU carry-out
//   carry_flag  current carry flag
//   level       FIFO occupancy
//
// Build option:
//   ALU_ISSUE_CARRY_FWD_EN  when defined, the ALU carry is forwarded
//   straight into cin. A consuming op then waits only one edge after the
//   previous issue instead of two.
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_issue_if.slave             cmd,
    input  logic                   flag_clr,
    output logic                   valid_in,
    output logic [3:0]             a,
    output logic [3:0]             b,
    output logic [3:0]             ctl,
    output logic                   cin,
    input  logic                   valid_out,
    input  logic                   carry,
    output logic                   carry_flag,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBB = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_PASS = 4'h7
    } opcode_e;

    logic [3:0]    mem_a   [DEPTH];
    logic [3:0]    mem_b   [DEPTH];
    logic [3:0]    mem_ctl [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          h1;
    logic          h2;

    logic          push;
    logic          issue;
    logic          hazard;
    logic          head_consumes;
    logic          cin_sel;
    logic [3:0]    head_a;
    logic [3:0]    head_b;
    logic [3:0]    head_ctl;

    // Ready depends only on occupancy, so a full FIFO refuses a command
    // even in a cycle where the head is being popped.
    assign cmd.cmd_ready = (level < LW'(DEPTH));
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    assign head_a        = mem_a[rd_ptr];
    assign head_b        = mem_b[rd_ptr];
    assign head_ctl      = mem_ctl[rd_ptr];
    assign head_consumes = (head_ctl == OP_ADDC) || (head_ctl == OP_SUBB);

    // The ALU is assumed to answer exactly one cycle after it samples
    // valid_in.  Hazards are derived from the issue history alone, never
    // from valid_out, so an op the ALU silently drops cannot block issue.
`ifdef ALU_ISSUE_CARRY_FWD_EN
    assign hazard  = head_consumes && h1;
    assign cin_sel = valid_out ? carry : carry_flag;
`else
    assign hazard  = head_consumes && (h1 || h2);
    assign cin_sel = carry_flag;
`endif

    // An empty FIFO never issues, so a freshly pushed command is first
    // eligible at the edge after the one that stored it.
    assign issue = (level != '0) && !hazard;

    // Command storage; occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= cmd.cmd_a;
            mem_b[wr_ptr]   <= cmd.cmd_b;
            mem_ctl[wr_ptr] <= cmd.cmd_ctl;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, issue})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_in <= 1'b0;
            a        <= '0;
            b        <= '0;
            ctl      <= '0;
            cin      <= 1'b0;
            h1       <= 1'b0;
            h2       <= 1'b0;
        end else begin
            valid_in <= issue;
            h1       <= issue;
            h2       <= h1;
            if (issue) begin
                a   <= head_a;
                b   <= head_b;
                ctl <= head_ctl;
                cin <= cin_sel;
            end
        end
    end

    // A clear wins over a result arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_flag <= 1'b0;
        end else if (flag_clr) begin
            carry_flag <= 1'b0;
        end else if (valid_out) begin
            carry_flag <= carry;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
// Self-checking bench for alu_issue with DEPTH=4.  A scoreboard queue
// holds accepted commands and is compared against every issued op; a
// one-cycle ALU model produces valid_out/carry.  Occupancy, ready and the
// carry flag are checked against bench models every cycle.
module tb_alu_issue;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDC  = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SUBB  = 4'h3;
    localparam logic [3:0] OP_UNDEF = 4'hF;

`ifdef ALU_ISSUE_CARRY_FWD_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ctl;
        logic       cin;
    } issue_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          flag_clr  = 1'b0;
    logic          valid_in;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [3:0]    ctl;
    logic          cin;
    logic          valid_out = 1'b0;
    logic          carry     = 1'b0;
    logic          carry_flag;
    logic [LW-1:0] level;

    alu_issue_if cmd_if ();

    alu_issue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .flag_clr   (flag_clr),
        .valid_in   (valid_in),
        .a          (a),
        .b          (b),
        .ctl        (ctl),
        .cin        (cin),
        .valid_out  (valid_out),
        .carry      (carry),
        .carry_flag (carry_flag),
        .level      (level)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          model_level = 0;
    logic        model_flag  = 1'b0;
    logic        pend_push   = 1'b0;
    logic [11:0] exp_q [$];
    issue_t      issue_log [$];

    int          n0;
    int          p0;
    bit          full_seen;
    issue_t      e0;
    issue_t      e1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic alu_carry(input logic [3:0] fa, input logic [3:0] fb,
                                       input logic [3:0] fc, input logic fcin);
        logic [4:0] s;
        case (fc)
            OP_ADD:  s = {1'b0, fa} + {1'b0, fb};
            OP_ADDC: s = {1'b0, fa} + {1'b0, fb} + {4'b0, fcin};
            OP_SUB:  s = {1'b0, fa} - {1'b0, fb};
            OP_SUBB: s = {1'b0, fa} - {1'b0, fb} - {4'b0, fcin};
            default: s = 5'b0;
        endcase
        return s[4];
    endfunction

    // One-cycle ALU: codes above 7 are dropped without a valid_out.
    always @(posedge clk) begin
        valid_out <= (valid_in === 1'b1) && (ctl <= 4'h7);
        carry     <= alu_carry(a, b, ctl, cin);
    end

    // Acceptance and carry-flag models, evaluated on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            model_level = 0;
            pend_push   = 1'b0;
            model_flag  = 1'b0;
        end else begin
            pend_push = cmd_if.cmd_valid && (model_level < DEPTH);
            if (pend_push) begin
                exp_q.push_back({cmd_if.cmd_a, cmd_if.cmd_b, cmd_if.cmd_ctl});
            end
            if (flag_clr) begin
                model_flag = 1'b0;
            end else if (valid_out) begin
                model_flag = carry;
            end
        end
    end

    // Output checks half a cycle after the active edge.
    always @(negedge clk) begin
        logic [11:0] e;
        issue_t      rec;
        if (reset) begin
            model_level = 0;
            pend_push   = 1'b0;
            exp_q.delete();
            checkOutput("rst_valid_in", 32'(valid_in), 32'd0);
            checkOutput("rst_level", 32'(level), 32'd0);
            checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
            checkOutput("rst_flag", 32'(carry_flag), 32'd0);
        end else begin
            if (valid_in === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_issue", 32'(valid_in), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_a", 32'(a), 32'(e[11:8]));
                    checkOutput("sb_b", 32'(b), 32'(e[7:4]));
                    checkOutput("sb_ctl", 32'(ctl), 32'(e[3:0]));
                end
                rec.cyc = cyc;
                rec.a   = a;
                rec.b   = b;
                rec.ctl = ctl;
                rec.cin = cin;
                issue_log.push_back(rec);
            end
            model_level = model_level + (pend_push ? 1 : 0) - ((valid_in === 1'b1) ? 1 : 0);
            pend_push   = 1'b0;
            checkOutput("level", 32'(level), 32'(model_level));
            checkOutput("cmd_ready", 32'(cmd_if.cmd_ready), 32'(model_level < DEPTH));
            checkOutput("carry_flag", 32'(carry_flag), 32'(model_flag));
        end
    end

    // Presents one command and returns just after the edge that took it.
    task automatic applyStimulus(input logic [3:0] ia, input logic [3:0] ib,
                                 input logic [3:0] ic);
        bit will;
        bit done;
        done = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_a     = ia;
        cmd_if.cmd_b     = ib;
        cmd_if.cmd_ctl   = ic;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #1;
            will = (model_level < DEPTH);
            @(posedge clk);
            #2;
            if (will) done = 1'b1;
        end
        checkOutput("push_done", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        cmd_if.cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input string tag);
        bit done;
        done = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && model_level == 0) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
        @(posedge clk);
        #2;
    endtask

    // Streams ADD_c commands until the modelled occupancy hits the target;
    // returns just after the negedge where it was reached, command still up.
    task automatic fillTo(input int target, output bit reached);
        reached          = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_a     = 4'h0;
        cmd_if.cmd_b     = 4'h1;
        cmd_if.cmd_ctl   = OP_ADDC;
        for (int i = 0; i < 30 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (model_level == target) begin
                reached = 1'b1;
            end else begin
                @(posedge clk);
                #2;
                cmd_if.cmd_a = cmd_if.cmd_a + 4'h1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_a     = 4'h0;
        cmd_if.cmd_b     = 4'h0;
        cmd_if.cmd_ctl   = 4'h0;

        // Reset held, then released with nothing offered.
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        idle(2);
        @(negedge clk);
        checkOutput("t1_valid_in", 32'(valid_in), 32'd0);
        checkOutput("t1_a", 32'(a), 32'd0);
        checkOutput("t1_b", 32'(b), 32'd0);
        checkOutput("t1_ctl", 32'(ctl), 32'd0);
        checkOutput("t1_cin", 32'(cin), 32'd0);
        checkOutput("t1_flag", 32'(carry_flag), 32'd0);
        checkOutput("t1_level", 32'(level), 32'd0);
        checkOutput("t1_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #2;

        // Four ADDs back to back issue on four consecutive edges, in order.
        $display("[TB] back-to-back ADD");
        n0 = issue_log.size();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'(k + 1), 4'(k + 2), OP_ADD);
        end
        waitDrain("t2_drain");
        checkOutput("t2_count", 32'(issue_log.size()), 32'(n0 + 4));
        if (issue_log.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t2_order", 32'(issue_log[n0 + k].a), 32'(k + 1));
            end
            for (int k = 1; k < 4; k++) begin
                checkOutput("t2_gap", 32'(issue_log[n0 + k].cyc - issue_log[n0 + k - 1].cyc), 32'd1);
            end
        end

        // Stalled ADD_c stream fills the FIFO; a further command is refused.
        $display("[TB] fill to full");
        idle(3);
        fillTo(DEPTH, full_seen);
        checkOutput("t3_full_seen", 32'(full_seen), 32'd1);
        checkOutput("t3_full_level", 32'(level), 32'(DEPTH));
        checkOutput("t3_refuse", 32'(cmd_if.cmd_ready), 32'd0);
        @(posedge clk);
        #2;
        waitDrain("t3_drain");

        // Carry dependency: ADD F+1 then ADD_c 0+0 must see cin=1.
        $display("[TB] carry dependency");
        idle(3);
        n0 = issue_log.size();
        applyStimulus(4'hF, 4'h1, OP_ADD);
        applyStimulus(4'h0, 4'h0, OP_ADDC);
        waitDrain("t4_drain");
        checkOutput("t4_count", 32'(issue_log.size()), 32'(n0 + 2));
        if (issue_log.size() >= n0 + 2) begin
            e0 = issue_log[n0];
            e1 = issue_log[n0 + 1];
            checkOutput("t4_cin", 32'(e1.cin), 32'd1);
            checkOutput("t4_gap", 32'(e1.cyc - e0.cyc), 32'(GAP));
        end

        // flag_clr on the same edge as a carry=1 result wins.
        $display("[TB] flag clear priority");
        idle(3);
        applyStimulus(4'hF, 4'h1, OP_ADD);
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        checkOutput("t5_alu_valid", 32'(valid_out), 32'd1);
        checkOutput("t5_alu_carry", 32'(carry), 32'd1);
        flag_clr = 1'b1;
        @(posedge clk);
        #2;
        flag_clr = 1'b0;
        @(negedge clk);
        checkOutput("t5_clr", 32'(carry_flag), 32'd0);
        @(posedge clk);
        #2;
        applyStimulus(4'h5, 4'h3, OP_SUBB);
        waitDrain("t5_drain");
        if (issue_log.size() > 0) begin
            e1 = issue_log[issue_log.size() - 1];
            checkOutput("t5_subb_ctl", 32'(e1.ctl), 32'(OP_SUBB));
            checkOutput("t5_subb_cin", 32'(e1.cin), 32'd0);
        end

        // An op the ALU drops must not block the next one or touch the flag.
        $display("[TB] dropped opcode");
        idle(3);
        applyStimulus(4'hF, 4'h1, OP_ADD);
        waitDrain("t6_pre_drain");
        idle(3);
        checkOutput("t6_pre_flag", 32'(carry_flag), 32'd1);
        n0 = issue_log.size();
        applyStimulus(4'h1, 4'h2, OP_UNDEF);
        applyStimulus(4'h2, 4'h3, OP_ADD);
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_flag_held", 32'(carry_flag), 32'd1);
        @(posedge clk);
        #2;
        waitDrain("t6_drain");
        checkOutput("t6_count", 32'(issue_log.size()), 32'(n0 + 2));
        if (issue_log.size() >= n0 + 2) begin
            checkOutput("t6_gap", 32'(issue_log[n0 + 1].cyc - issue_log[n0].cyc), 32'd1);
        end

        // Reset mid-stream with three queued commands discards them.
        $display("[TB] reset mid-stream");
        idle(3);
        fillTo(3, full_seen);
        checkOutput("t7_reached", 32'(full_seen), 32'd1);
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        #1;
        checkOutput("t7_valid_in", 32'(valid_in), 32'd0);
        checkOutput("t7_level", 32'(level), 32'd0);
        checkOutput("t7_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        n0 = issue_log.size();
        idle(10);
        checkOutput("t7_no_issue", 32'(issue_log.size()), 32'(n0));

        // Push into an empty FIFO issues on the following edge.
        $display("[TB] minimum latency");
        applyStimulus(4'h7, 4'h8, OP_ADD);
        p0 = cyc;
        waitDrain("t8_drain");
        checkOutput("t8_count", 32'(issue_log.size()), 32'(n0 + 1));
        if (issue_log.size() >= n0 + 1) begin
            checkOutput("t8_latency", 32'(issue_log[n0].cyc - p0), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth, power of two in range 2..16.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 The block SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 The block SHALL have ports cmd_a and cmd_b  input  4 each  command operands.
REQ-007 The block SHALL have port cmd_ctl  input  4  opcode from the shared opcode_e enumeration.
REQ-008 The block SHALL have port flag_clr  input  1  synchronous clear of the carry flag.
REQ-009 The block SHALL have ports valid_in (1), a (4), b (4), ctl (4) and cin (1)  output  issued ALU operation, all registered.
REQ-010 The block SHALL have ports valid_out and carry  input  1 each  ALU result-valid and carry-out.
REQ-011 The block SHALL have ports carry_flag (output, 1) = current carry flag and level (output, $clog2(DEPTH)+1) = FIFO occupancy.

Function
REQ-012 Acceptance SHALL occur when cmd_valid and cmd_ready are both 1; cmd_ready = (level < DEPTH), independent of a same-cycle pop, so a full FIFO refuses commands even while popping.
REQ-013 Accepted {cmd_a, cmd_b, cmd_ctl} SHALL be stored in FIFO order, with read and write pointers wrapping modulo DEPTH.
REQ-014 Carry-consuming opcodes SHALL be ADD_c and SUB_b; every other ctl value, undefined codes included, is non-consuming and issued unchanged.
REQ-015 Each edge the head entry SHALL issue if the FIFO is non-empty and no hazard applies: valid_in<=1, a/b/ctl<=head fields, cin<=selected carry, entry popped; otherwise valid_in<=0 and a/b/ctl/cin hold their values.
REQ-016 The block SHALL keep a 2-bit issue history (h1 = issued at previous edge, h2 = issued two edges ago), shifted every edge.
REQ-017 Non-consuming heads SHALL never stall, giving back-to-back issue at one op per cycle.
REQ-018 carry_flag SHALL load carry at each edge where valid_out=1; flag_clr=1 forces 0 and overrides a coincident valid_out.
REQ-019 The ALU result latency SHALL be taken as exactly one cycle after valid_in is sampled; the block SHALL NOT count or wait on valid_out for hazard purposes, so an ALU-dropped invalid opcode cannot deadlock issue.
REQ-020 A push to an empty FIFO SHALL become eligible for issue at the following edge, for a minimum command-to-valid_in latency of 2 edges.
REQ-021 Simultaneous push and pop SHALL leave level unchanged.

Reset
REQ-022 While reset=1 the block SHALL force valid_in, a, b, ctl, cin, carry_flag, the history bits, both pointers and level to 0, with cmd_ready=1 and the FIFO empty.
REQ-023 Reset assertion mid-operation SHALL discard queued commands; valid_out seen after reset release still updates carry_flag.

Configuration
REQ-024 With macro ALU_ISSUE_CARRY_FWD_EN defined, a consuming head SHALL stall only while h1=1, and when valid_out=1 at the issue edge cin SHALL load carry directly (forwarded), otherwise carry_flag; minimum spacing after a previous op is 2 edges.
REQ-025 With ALU_ISSUE_CARRY_FWD_EN undefined, a consuming head SHALL stall while h1 or h2 is 1, and cin SHALL always load carry_flag; minimum spacing is 3 edges.

Verification
REQ-026 The bench SHALL cover: reset held, then released with cmd_valid=0 -> all outputs 0, cmd_ready=1, level=0.
REQ-027 The bench SHALL cover: 4 ADD commands pushed on consecutive cycles (DEPTH=4, cmd_valid held) -> valid_in high 4 consecutive cycles, a/b in push order; a 5th command is refused while level=4.
REQ-028 The bench SHALL cover: ADD a=4'hF b=4'h1 then ADD_c a=4'h0 b=4'h0 with the ALU model returning carry=1 -> ADD_c issued with cin=1; gap between valid_in pulses is 3 edges without the macro and 2 edges with it.
REQ-029 The bench SHALL cover: flag_clr=1 coincident with valid_out=1 and carry=1 -> carry_flag=0; a following SUB_b issues with cin=0.
REQ-030 The bench SHALL cover: an undefined ctl code, with the ALU giving no valid_out, followed by ADD -> no deadlock, ADD issues on the next edge, carry_flag unchanged.
REQ-031 The bench SHALL cover: reset asserted with level=3 mid-stream -> valid_in=0 and level=0 immediately, and none of the discarded commands issue after release.
